// File: rtl/serial_alu.sv
// Slice-serial ADD/SUB/AND/OR ALU: SLICE bits per cycle with a carry chained
// between slices, and a valid/ready handshake on both sides.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic [SLICE:0]   sum;
  logic [SLICE-1:0] sl;
  logic [WIDTH-1:0] acc_nx;
  logic             last;
  logic             arith;

  assign arith = ~op_q[1];
  assign last  = (cnt_q == CW'(NSLICE - 1));

  // Operands shift right each cycle, so the live slice is always the low bits.
  assign sum = {1'b0, a_q[SLICE-1:0]}
             + {1'b0, b_q[SLICE-1:0]}
             + {{SLICE{1'b0}}, carry_q};

  always_comb begin
    sl = sum[SLICE-1:0];
    unique case (op_q)
      2'b10:   sl = a_q[SLICE-1:0] & b_q[SLICE-1:0];
      2'b11:   sl = a_q[SLICE-1:0] | b_q[SLICE-1:0];
      default: sl = sum[SLICE-1:0];
    endcase
  end

  // Result slices enter at the top and migrate down into place.
  assign acc_nx = (acc_q >> SLICE) | (WIDTH'(sl) << (WIDTH - SLICE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flg_d   = flg_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (ALUControl == 2'b01) ? ~b : b;
          op_d    = ALUControl;
          cnt_d   = '0;
          carry_d = ALUControl[0];
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        cnt_d = cnt_q + CW'(1);
        if (arith) carry_d = sum[SLICE];
        if (last) begin
          state_d = DONE;
          res_d   = acc_nx;
          // a_q/b_q now hold the top slice, so bit SLICE-1 is the sign bit.
          flg_d   = {acc_nx[WIDTH-1],
                     acc_nx == '0,
                     arith & sum[SLICE],
                     arith & (a_q[SLICE-1] == b_q[SLICE-1])
                           & (acc_nx[WIDTH-1] != a_q[SLICE-1])};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign ALUFlags  = flg_q;

endmodule

// File: tb/tb_serial_alu.sv
// Random and directed checks of serial_alu against a whole-word arithmetic
// model, compared on every cycle.
module tb_serial_alu;
  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   ctl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [3:0]   ALUFlags;

  serial_alu #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ctl),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .ALUFlags(ALUFlags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic         e_ir, e_ov;
  logic [W-1:0] e_res;
  logic [3:0]   e_flg;
  logic [W-1:0] held_r;
  logic [3:0]   held_f;
  bit           chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Whole-word model: SUB is a true subtraction, C = no borrow.
  function automatic void ref_alu(input logic [1:0] op,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] r,
                                  output logic [3:0] f);
    logic [W:0] s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      2'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      2'd1: begin
        s = {1'b0, x} - {1'b0, y};
        r = s[W-1:0];
        c = ~s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      2'd2: r = x & y;
      default: r = x | y;
    endcase
    f = {r[W-1], r == '0, c, v};
  endfunction

  task automatic set_exp(input logic ir, input logic ov,
                         input logic [W-1:0] r, input logic [3:0] f);
    e_ir  = ir;
    e_ov  = ov;
    e_res = r;
    e_flg = f;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready", in_ready, e_ir);
      check("out_valid", out_valid, e_ov);
      check("Result", Result, e_res);
      check("ALUFlags", ALUFlags, e_flg);
    end
  end

  task automatic garbage();
    in_valid = 1'($urandom);
    a = $urandom;
    b = $urandom;
    ctl = 2'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      out_ready = 1'($urandom);
      set_exp(1'b1, 1'b0, held_r, held_f);
    end
  endtask

  // abort_at > 0: assert reset at that negedge into the run.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int stall,
                       input int abort_at);
    logic [W-1:0] r;
    logic [3:0] f;
    ref_alu(op, x, y, r, f);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    ctl = op;
    out_ready = 1'($urandom);
    set_exp(1'b0, 1'b0, held_r, held_f);
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_Result", Result, '0);
        check("rst_ALUFlags", ALUFlags, 4'b0000);
        held_r = '0;
        held_f = '0;
        set_exp(1'b1, 1'b0, held_r, held_f);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        set_exp(1'b1, 1'b0, held_r, held_f);
        return;
      end
      garbage();
      out_ready = 1'($urandom);
      set_exp(1'b0, 1'b0, held_r, held_f);
    end
    @(negedge clk);
    garbage();
    out_ready = 1'b0;
    set_exp(1'b0, 1'b1, r, f);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      garbage();
      out_ready = 1'b0;
      set_exp(1'b0, 1'b1, r, f);
    end
    @(negedge clk);
    garbage();
    out_ready = 1'b1;
    held_r = r;
    held_f = f;
    set_exp(1'b1, 1'b0, r, f);
  endtask

  task automatic pin(input string nm, input logic [1:0] op,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input logic [3:0] ef);
    logic [W-1:0] r;
    logic [3:0] f;
    ref_alu(op, x, y, r, f);
    check({nm, "_model_res"}, r, er);
    check({nm, "_model_flg"}, f, ef);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    ctl = '0;
    held_r = '0;
    held_f = '0;
    set_exp(1'b1, 1'b0, '0, 4'b0000);
    #12;
    check("por_in_ready", in_ready, 1'b1);
    check("por_out_valid", out_valid, 1'b0);
    check("por_Result", Result, '0);
    check("por_ALUFlags", ALUFlags, 4'b0000);

    pin("add_ff_1", 2'd0, 32'h0000_00FF, 32'h1, 32'h0000_0100, 4'b0000);
    pin("sub_5_5", 2'd1, 32'd5, 32'd5, 32'h0, 4'b0110);
    pin("sub_0_1", 2'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000);
    pin("add_ovf", 2'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    pin("add_wrap", 2'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
    pin("and", 2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000);
    pin("or", 2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'b1000);
    pin("add_3_4", 2'd0, 32'd3, 32'd4, 32'd7, 4'b0000);

    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    do_op(2'd0, 32'h0000_00FF, 32'h1, 0, 0);
    do_op(2'd1, 32'd5, 32'd5, 0, 0);
    idle(1);
    do_op(2'd1, 32'd0, 32'd1, 1, 0);
    do_op(2'd0, 32'h7FFF_FFFF, 32'h1, 0, 0);
    do_op(2'd0, 32'hFFFF_FFFF, 32'h1, 0, 0);
    do_op(2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    do_op(2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 0);
    do_op(2'd0, 32'h1234_5678, 32'h0FED_CBA9, 0, 3);
    idle(1);
    do_op(2'd0, 32'd3, 32'd4, 0, 0);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      do_op(2'($urandom), pick(), pick(), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter SLICE, default 8, bits processed per cycle; SHALL be >= 1 and divide WIDTH exactly; NSLICE = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set and opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ALUControl  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 out_valid  output  1  Result/ALUFlags hold a completed operation.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 Result  output  WIDTH  registered result.
REQ-013 ALUFlags  output  4  registered flags {N,Z,C,V}, bit 3 = N.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); both registered-state decodes, no combinational input-to-output path.
REQ-016 IDLE: on a rising edge with in_valid=1, the block SHALL latch a, b, ALUControl, clear the slice counter, preset the carry register to ALUControl[0] (1 for SUB), and enter RUN; in_valid=0 keeps IDLE.
REQ-017 Operand B selection SHALL be b for ADD, ~b for SUB; AND/OR SHALL use b unmodified.
REQ-018 RUN: each cycle SHALL compute slice k (bits k*SLICE .. k*SLICE+SLICE-1) as A+Bsel+carry (ADD/SUB), A&B (AND) or A|B (OR), store it, update the carry register with the slice carry-out (ADD/SUB only), and increment k.
REQ-019 RUN SHALL last exactly NSLICE cycles; after processing slice NSLICE-1 the FSM SHALL enter DONE and load Result and ALUFlags on that same edge.
REQ-020 Latency: out_valid SHALL rise exactly NSLICE clock edges after the accepting edge (4 cycles at defaults).
REQ-021 Flags: N = Result[WIDTH-1]; Z = (Result == 0); C = carry out of bit WIDTH-1 for ADD/SUB (SUB: 1 = no borrow), 0 for AND/OR; V = (A[W-1] == Bsel[W-1]) && (Result[W-1] != A[W-1]) for ADD/SUB, 0 for AND/OR.
REQ-022 DONE: Result and ALUFlags SHALL stay stable while out_ready=0 (no limit on stall length); on an edge with out_ready=1 the FSM SHALL return to IDLE.
REQ-023 Result and ALUFlags SHALL change only on the RUN->DONE edge or on reset; they retain the last completed values in IDLE and RUN.
REQ-024 Inputs a, b, ALUControl, in_valid SHALL be ignored outside IDLE; changes during RUN SHALL not affect the operation in flight.
REQ-025 No overlap: a new operation is accepted no earlier than the edge after the DONE->IDLE edge; peak throughput one op per NSLICE+2 cycles.
REQ-026 Carry chaining across slices SHALL give results bit-identical to a single WIDTH-bit ripple adder for all operands, including full wrap-around (modulo 2^WIDTH).

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, Result 0, ALUFlags 4'b0000, out_valid 0, slice counter 0, carry 0, independent of clk.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse; in_ready SHALL read 1 once reset is deasserted, and the next accepted operation SHALL complete normally.

Verification (WIDTH=32, SLICE=8)
REQ-029 ADD 0x000000FF + 0x00000001 -> Result 0x00000100, ALUFlags 0000, out_valid exactly 4 edges after accept.
REQ-030 SUB 5 - 5 -> 0x00000000, ALUFlags 0110; SUB 0 - 1 -> 0xFFFFFFFF, ALUFlags 1000.
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, ALUFlags 1001; ADD 0xFFFFFFFF + 1 -> 0x00000000, ALUFlags 0110.
REQ-032 AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000, ALUFlags 1000; OR same operands -> 0xFFF0FFF0, ALUFlags 1000.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while toggling a/b/in_valid -> Result/ALUFlags unchanged, in_ready=0; out_ready=1 -> IDLE next edge, then next op accepted.
REQ-034 Assert reset after 2 RUN cycles of ADD -> out_valid stays 0, Result 0, ALUFlags 0000; after release, ADD 3 + 4 -> 0x00000007, ALUFlags 0000.
